// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default sizes for mem_port_arbiter (state enum, requester id, DW/AW/DEPTH defaults)
package mem_arb_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;
  localparam int DEPTH_DEF = 500;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {FETCH, DATA} id_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request+ack, shared rdata/err/busy and memory bus; master = requesters and memory, slave = arbiter
interface mem_port_arbiter_if #(
  parameter int DW = mem_arb_pkg::DW_DEF,
  parameter int AW = mem_arb_pkg::AW_DEF
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_dataout;
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
    input  f_ack, d_ack, rdata, err, busy, mem_addr, mem_datain, mem_re, mem_we
  );
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
    output f_ack, d_ack, rdata, err, busy, mem_addr, mem_datain, mem_re, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick (req[0]=FETCH, req[1]=DATA, last = previous winner -> one-hot gnt, valid)
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  id_e        last,
  output logic [1:0] gnt,
  output logic       valid
);
  always_comb begin
    gnt = &req ? (last == FETCH ? 2'b10 : 2'b01) : req;
    valid = |req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch/data access to a single-port memory (clk, rst_n sync active-low, bus = mem_port_arbiter_if.slave; MEM_ARB_ADDR_CHECK_EN enables address range check)
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_e state_q, state_d;
  id_e last_q, last_d, id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] gnt;
  logic valid, grant, oor;
  rr_arb2 u_arb (.req({bus.d_req, bus.f_req}), .last(last_q), .gnt(gnt), .valid(valid));
  assign oor = CHK && (addr_q >= AW'(DEPTH));
  always_comb begin
    grant = state_q == IDLE && valid;
    state_d = state_q == IDLE ? (valid ? ACCESS : IDLE) : (state_q == ACCESS ? RESP : IDLE);
    id_d = grant ? (gnt[1] ? DATA : FETCH) : id_q;
    last_d = grant ? id_d : last_q;
    addr_d = grant ? (gnt[1] ? bus.d_addr : bus.f_addr) : addr_q;
    we_d = grant ? gnt[1] && bus.d_we : we_q;
    wdata_d = grant && gnt[1] ? bus.d_wdata : wdata_q;
    rdata_d = state_q == ACCESS && !we_q ? (oor ? '0 : bus.mem_dataout) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= FETCH;
      id_q <= FETCH;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.mem_addr = addr_q;
  assign bus.mem_datain = wdata_q;
  assign bus.mem_re = rst_n && state_q == ACCESS && !we_q && !oor;
  assign bus.mem_we = rst_n && state_q == ACCESS && we_q && !oor;
  assign bus.f_ack = state_q == RESP && id_q == FETCH;
  assign bus.d_ack = state_q == RESP && id_q == DATA;
  assign bus.err = state_q == RESP && oor;
  assign bus.busy = state_q != IDLE;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with directed and randomized fetch/data traffic
module tb_mem_port_arbiter;
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 500;
  typedef struct {logic wr; logic [15:0] rdata; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre = 1'b0;
  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] last_rd = 16'h0;
  exp_t fq[$], dq[$];
  int ack_id[$], ack_cyc[$];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [15:0] iv(input int a);
    return a == 3 ? 16'h1103 : 16'(a * 37) ^ 16'h5A5A;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!pre) begin
      for (int i = 0; i < 1024; i++) mem[i] <= iv(i);
      pre <= 1'b1;
    end else if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_datain;
  end
  assign bus.mem_dataout = bus.mem_re ? mem[bus.mem_addr[9:0]] : 16'hDEAD;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic mk(input logic wr, input logic [15:0] a, input logic [15:0] wd, output exp_t x);
    logic o;
    o = CHK && a >= 16'(DEPTH);
    x.wr = wr;
    x.err = o;
    x.rdata = (wr || o) ? 16'h0 : ref_mem[a[9:0]];
    if (wr && !o) ref_mem[a[9:0]] = wd;
  endtask
  task automatic cmp(input string n, input exp_t x);
    chk({n, "_err"}, 32'(bus.err), 32'(x.err));
    chk({n, "_rdata"}, 32'(bus.rdata), 32'(x.wr ? last_rd : x.rdata));
    if (!x.wr) last_rd = x.rdata;
  endtask
  always @(negedge clk) begin
    if (!rst_n) last_rd = 16'h0;
    chk("re_we_exclusive", 32'(bus.mem_re & bus.mem_we), 0);
    if (bus.f_ack && bus.d_ack) chk("single_ack", 32'(bus.f_ack & bus.d_ack), 0);
    if (bus.f_ack) begin
      ack_id.push_back(0);
      ack_cyc.push_back(cyc);
      chk("f_ack_expected", 32'(fq.size() != 0), 1);
      if (fq.size() != 0) cmp("fetch", fq.pop_front());
    end
    if (bus.d_ack) begin
      ack_id.push_back(1);
      ack_cyc.push_back(cyc);
      chk("d_ack_expected", 32'(dq.size() != 0), 1);
      if (dq.size() != 0) cmp("data", dq.pop_front());
    end
  end
  task automatic align();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input logic [15:0] a);
    exp_t x;
    int n = 0;
    mk(1'b0, a, 16'h0, x);
    fq.push_back(x);
    bus.f_req = 1'b1;
    bus.f_addr = a;
    do begin align(); n++; end while (!bus.f_ack && n < 20);
    chk("f_ack_in_time", 32'(bus.f_ack), 1);
    bus.f_req = 1'b0;
  endtask
  task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
    exp_t x;
    int n = 0;
    mk(we, a, wd, x);
    dq.push_back(x);
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
    do begin align(); n++; end while (!bus.d_ack && n < 20);
    chk("d_ack_in_time", 32'(bus.d_ack), 1);
    bus.d_req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    exp_t x;
    int last, w;
    for (int i = 0; i < 1024; i++) ref_mem[i] = iv(i);
    bus.f_req = 1'b1;
    bus.f_addr = 16'd3;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0010;
    bus.d_wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 32'({bus.f_ack, bus.d_ack, bus.err, bus.busy, bus.mem_re, bus.mem_we}), 0);
    chk("reset_rdata", 32'(bus.rdata), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    chk("reset_mem_datain", 32'(bus.mem_datain), 0);
    for (int i = 0; i < 2; i++) begin
      mk(1'b0, 16'd3, 16'h0, x);
      fq.push_back(x);
      mk(1'b0, 16'h0010, 16'h0, x);
      dq.push_back(x);
    end
    ack_id.delete();
    ack_cyc.delete();
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (3) align();
    chk("contention_ack_count", 32'(ack_id.size()), 4);
    last = 0;
    for (int i = 0; i < 4; i++) begin
      w = last == 0 ? 1 : 0;
      last = w;
      if (i < ack_id.size()) chk($sformatf("grant_order_%0d", i), 32'(ack_id[i]), 32'(w));
      if (i > 0 && i < ack_cyc.size()) chk($sformatf("grant_spacing_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 3);
    end
    fork
      do_fetch(16'd3);
      begin
        repeat (2) @(negedge clk);
        chk("fetch_mem_re", 32'(bus.mem_re), 1);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 3);
      end
    join
    align();
    fork
      do_data(1'b1, 16'h0010, 16'hBEEF);
      begin
        repeat (2) @(negedge clk);
        chk("write_mem_we", 32'(bus.mem_we), 1);
        chk("write_mem_re", 32'(bus.mem_re), 0);
        chk("write_mem_datain", 32'(bus.mem_datain), 'hBEEF);
        @(negedge clk);
        chk("write_we_one_cycle", 32'(bus.mem_we), 0);
      end
    join
    align();
    do_data(1'b0, 16'h0010, 16'h0);
    align();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 16'd5;
    bus.d_wdata = 16'h1234;
    align();
    chk("midrst_busy_access", 32'(bus.busy), 1);
    rst_n = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 0);
    align();
    chk("midrst_busy_idle", 32'(bus.busy), 0);
    chk("midrst_no_ack", 32'(bus.d_ack), 0);
    rst_n = 1'b1;
    repeat (2) align();
    chk("midrst_word5", 32'(mem[5]), 32'(ref_mem[5]));
    fork
      do_data(1'b0, 16'd500, 16'h0);
      begin
        repeat (2) @(negedge clk);
        chk("oor_mem_re", 32'(bus.mem_re), CHK ? 0 : 1);
        chk("oor_mem_addr", 32'(bus.mem_addr), 500);
      end
    join
    align();
    fork
      repeat (30) begin
        repeat ($urandom_range(0, 2)) align();
        do_fetch($urandom_range(0, 9) == 0 ? 16'(600 + $urandom_range(0, 10)) : 16'($urandom_range(0, 63)));
      end
      repeat (30) begin
        repeat ($urandom_range(0, 2)) align();
        do_data(1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0 ? 16'(500 + $urandom_range(0, 10)) : 16'(64 + $urandom_range(0, 63)),
                16'($urandom));
      end
    join
    repeat (5) align();
    chk("fetch_queue_drained", 32'(fq.size()), 0);
    chk("data_queue_drained", 32'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
